// File: rtl/ka_encode_ctrl_3_1.sv
// ka_encode_ctrl_3_1
// Join controller closing the ka decode fork. The ka request is merged with
// one key branch, short-key (sk) or long-key (lk), chosen by k_ctrl when ka
// arrives. One joined request is issued downstream. After it completes, the
// ka channel and the selected branch are acked together for one cycle.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   t_ka_req     ka request (level, held until acked)
//   t_ka_ack     ka ack (one-cycle pulse)
//   k_ctrl       key control; bit 3 set (>=8) selects the lk branch
//   t_k_sk_req   short-key branch request
//   t_k_sk_ack   short-key branch ack (one-cycle pulse)
//   t_k_lk_req   long-key branch request
//   t_k_lk_ack   long-key branch ack (one-cycle pulse)
//   i_kj_req     joined downstream request (registered)
//   i_kj_ack     downstream ack
//   i_kj_lk      registered path tag, 1 = lk path
//   txn_cnt      completed-join counter (wraps)
//   err_timeout  sticky: stuck in COLLECT/ISSUE for TIMEOUT_CYC cycles
//   err_stray    sticky: request seen on the non-selected branch
//   err_clr      synchronous clear of both error flags (a set wins)
module ka_encode_ctrl_3_1 #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             t_ka_req,
  output logic             t_ka_ack,
  input  logic [3:0]       k_ctrl,
  input  logic             t_k_sk_req,
  output logic             t_k_sk_ack,
  input  logic             t_k_lk_req,
  output logic             t_k_lk_ack,
  output logic             i_kj_req,
  input  logic             i_kj_ack,
  output logic             i_kj_lk,
  output logic [CNT_W-1:0] txn_cnt,
  output logic             err_timeout,
  output logic             err_stray,
  input  logic             err_clr
);

  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_PRE = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ISSUE   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          lk_nxt;
  logic          sel_eff;
  logic          br_req;
  logic          other_req;
  logic          rel;
  logic          active;
  logic          stray_set;
  logic          timeout_set;
  logic [TW-1:0] timer;

  // In IDLE the path is decided from k_ctrl directly so a branch request
  // already present alongside ka can skip COLLECT; afterwards the captured
  // tag is authoritative and k_ctrl is ignored.
  assign sel_eff   = (state == IDLE) ? k_ctrl[3] : i_kj_lk;
  assign br_req    = sel_eff ? t_k_lk_req : t_k_sk_req;
  assign other_req = i_kj_lk ? t_k_sk_req : t_k_lk_req;

  assign active      = (state == COLLECT) || (state == ISSUE);
  assign stray_set   = active && other_req;
  assign timeout_set = active && (TIMEOUT_CYC != 0) && (timer == TO_PRE);

  always_comb begin
    state_nxt = state;
    lk_nxt    = i_kj_lk;
    rel       = 1'b0;
    case (state)
      IDLE: begin
        if (t_ka_req) begin
          lk_nxt    = k_ctrl[3];
          state_nxt = br_req ? ISSUE : COLLECT;
        end
      end
      COLLECT: begin
        if (br_req) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (i_kj_ack) begin
          state_nxt = RELEASE;
          rel       = 1'b1;
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are registered from next-state decode so they line up with the
  // state they belong to: i_kj_req for the whole of ISSUE, acks in RELEASE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      i_kj_req    <= 1'b0;
      i_kj_lk     <= 1'b0;
      t_ka_ack    <= 1'b0;
      t_k_sk_ack  <= 1'b0;
      t_k_lk_ack  <= 1'b0;
      txn_cnt     <= '0;
      timer       <= '0;
      err_timeout <= 1'b0;
      err_stray   <= 1'b0;
    end else begin
      state      <= state_nxt;
      i_kj_req   <= (state_nxt == ISSUE);
      i_kj_lk    <= lk_nxt;
      t_ka_ack   <= rel;
      t_k_sk_ack <= rel && !i_kj_lk;
      t_k_lk_ack <= rel && i_kj_lk;
      if (rel) begin
        txn_cnt <= txn_cnt + CNT_W'(1);
      end

      // Timer saturates at the limit so the flag condition cannot re-fire
      // after wrap during a very long stall.
      if (active) begin
        if (timer != TO_LIM) begin
          timer <= timer + TW'(1);
        end
      end else begin
        timer <= '0;
      end

      if (timeout_set) begin
        err_timeout <= 1'b1;
      end else if (err_clr) begin
        err_timeout <= 1'b0;
      end

      if (stray_set) begin
        err_stray <= 1'b1;
      end else if (err_clr) begin
        err_stray <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ka_encode_ctrl_3_1.sv
module tb_ka_encode_ctrl_3_1;

  logic       clk = 1'b0;
  logic       reset;
  logic       t_ka_req;
  logic       t_ka_ack;
  logic [3:0] k_ctrl;
  logic       t_k_sk_req;
  logic       t_k_sk_ack;
  logic       t_k_lk_req;
  logic       t_k_lk_ack;
  logic       i_kj_req;
  logic       i_kj_ack;
  logic       i_kj_lk;
  logic [1:0] txn_cnt;
  logic       err_timeout;
  logic       err_stray;
  logic       err_clr;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       lk;
    logic [1:0] cnt;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] exp_cnt = 2'd0;

  always #5 clk = ~clk;

  ka_encode_ctrl_3_1 #(.TIMEOUT_CYC(4), .CNT_W(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .t_ka_req    (t_ka_req),
    .t_ka_ack    (t_ka_ack),
    .k_ctrl      (k_ctrl),
    .t_k_sk_req  (t_k_sk_req),
    .t_k_sk_ack  (t_k_sk_ack),
    .t_k_lk_req  (t_k_lk_req),
    .t_k_lk_ack  (t_k_lk_ack),
    .i_kj_req    (i_kj_req),
    .i_kj_ack    (i_kj_ack),
    .i_kj_lk     (i_kj_lk),
    .txn_cnt     (txn_cnt),
    .err_timeout (err_timeout),
    .err_stray   (err_stray),
    .err_clr     (err_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_all();
    t_ka_req   = 1'b0;
    t_k_sk_req = 1'b0;
    t_k_lk_req = 1'b0;
    i_kj_ack   = 1'b0;
    k_ctrl     = 4'd0;
  endtask

  task automatic push_exp(input logic lk);
    exp_t e;
    exp_cnt = exp_cnt + 2'd1;
    e.lk    = lk;
    e.cnt   = exp_cnt;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    err_clr = 1'b0;
    drop_all();
    step();
    step();
    checks++;
    if ({t_ka_ack, t_k_sk_ack, t_k_lk_ack, i_kj_req, i_kj_lk} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outs: got %b want 00000",
               {t_ka_ack, t_k_sk_ack, t_k_lk_ack, i_kj_req, i_kj_lk});
    end
    checks++;
    if ({txn_cnt, err_timeout, err_stray} !== 4'b0) begin
      errors++;
      $display("FAIL reset_cnt_err: got %b want 0000", {txn_cnt, err_timeout, err_stray});
    end
    @(negedge clk);
    reset   = 1'b0;
    exp_cnt = 2'd0;
    sb.delete();
    step();
  endtask

  // Generic scoreboarded join; used for sequences of transactions.
  task automatic run_txn(input logic [3:0] kc, input int br_dly, input int ack_dly);
    logic sel;
    int   n;
    exp_t e;
    sel = (kc >= 4'd8);
    push_exp(sel);
    t_ka_req = 1'b1;
    k_ctrl   = kc;
    for (int i = 0; i < br_dly; i++) begin
      step();
      checks++;
      if (i_kj_req !== 1'b0) begin
        errors++;
        $display("FAIL txn_early_req: got %b want 0", i_kj_req);
      end
    end
    if (sel) t_k_lk_req = 1'b1;
    else     t_k_sk_req = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (i_kj_req !== 1'b1 && n < 8);
    checks++;
    if (i_kj_req !== 1'b1) begin
      errors++;
      $display("FAIL txn_req_wait: got %b want 1 within 8 cycles", i_kj_req);
    end
    checks++;
    if (i_kj_lk !== sel) begin
      errors++;
      $display("FAIL txn_lk_tag: got %b want %b", i_kj_lk, sel);
    end
    repeat (ack_dly) step();
    i_kj_ack = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (t_ka_ack !== 1'b1 && n < 8);
    checks++;
    if (t_ka_ack !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL txn_ack_wait: got ka_ack=%b queued=%0d want ack=1", t_ka_ack, sb.size());
    end else begin
      e = sb.pop_front();
      checks++;
      if ({t_k_sk_ack, t_k_lk_ack} !== {!e.lk, e.lk}) begin
        errors++;
        $display("FAIL txn_branch_ack: got sk=%b lk=%b want sk=%b lk=%b",
                 t_k_sk_ack, t_k_lk_ack, !e.lk, e.lk);
      end
      checks++;
      if (txn_cnt !== e.cnt) begin
        errors++;
        $display("FAIL txn_cnt: got %0d want %0d", txn_cnt, e.cnt);
      end
    end
    drop_all();
    step();
    checks++;
    if ({t_ka_ack, t_k_sk_ack, t_k_lk_ack, i_kj_req} !== 4'b0) begin
      errors++;
      $display("FAIL txn_ack_pulse: got %b want 0000",
               {t_ka_ack, t_k_sk_ack, t_k_lk_ack, i_kj_req});
    end
  endtask

  task automatic test_sk_basic();
    exp_t e;
    push_exp(1'b0);
    t_ka_req = 1'b1; k_ctrl = 4'd3; t_k_sk_req = 1'b1;
    step();
    checks++;
    if ({i_kj_req, i_kj_lk} !== 2'b10) begin
      errors++;
      $display("FAIL sk_cycle1: got req=%b lk=%b want req=1 lk=0", i_kj_req, i_kj_lk);
    end
    step();
    checks++;
    if ({i_kj_req, t_ka_ack} !== 2'b10) begin
      errors++;
      $display("FAIL sk_cycle2: got req=%b ka_ack=%b want req=1 ka_ack=0", i_kj_req, t_ka_ack);
    end
    i_kj_ack = 1'b1;
    step();
    e = sb.pop_front();
    checks++;
    if ({t_ka_ack, t_k_sk_ack, t_k_lk_ack, i_kj_req} !== {1'b1, !e.lk, e.lk, 1'b0}) begin
      errors++;
      $display("FAIL sk_cycle3_acks: got %b want %b",
               {t_ka_ack, t_k_sk_ack, t_k_lk_ack, i_kj_req}, {1'b1, !e.lk, e.lk, 1'b0});
    end
    checks++;
    if (txn_cnt !== e.cnt) begin
      errors++;
      $display("FAIL sk_cnt: got %0d want %0d", txn_cnt, e.cnt);
    end
    drop_all();
    step();
    checks++;
    if ({t_ka_ack, t_k_sk_ack, t_k_lk_ack} !== 3'b0) begin
      errors++;
      $display("FAIL sk_cycle4_acks: got %b want 000", {t_ka_ack, t_k_sk_ack, t_k_lk_ack});
    end
  endtask

  task automatic test_lk_late();
    exp_t e;
    push_exp(1'b1);
    t_ka_req = 1'b1; k_ctrl = 4'd8; i_kj_ack = 1'b1;
    repeat (5) step();
    checks++;
    if (i_kj_req !== 1'b0) begin
      errors++;
      $display("FAIL lk_wait_req: got %b want 0", i_kj_req);
    end
    t_k_lk_req = 1'b1;
    step();
    checks++;
    if ({i_kj_req, i_kj_lk} !== 2'b11) begin
      errors++;
      $display("FAIL lk_cycle6: got req=%b lk=%b want 1 1", i_kj_req, i_kj_lk);
    end
    step();
    e = sb.pop_front();
    checks++;
    if ({t_ka_ack, t_k_sk_ack, t_k_lk_ack} !== {1'b1, !e.lk, e.lk}) begin
      errors++;
      $display("FAIL lk_cycle7_acks: got %b want %b",
               {t_ka_ack, t_k_sk_ack, t_k_lk_ack}, {1'b1, !e.lk, e.lk});
    end
    checks++;
    if (txn_cnt !== e.cnt) begin
      errors++;
      $display("FAIL lk_cnt: got %0d want %0d", txn_cnt, e.cnt);
    end
    drop_all();
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  task automatic test_stray();
    t_ka_req = 1'b1; k_ctrl = 4'd2; t_k_lk_req = 1'b1;
    repeat (3) step();
    checks++;
    if ({err_stray, i_kj_req, t_ka_ack, t_k_sk_ack, t_k_lk_ack} !== 5'b10000) begin
      errors++;
      $display("FAIL stray_flag: got %b want 10000",
               {err_stray, i_kj_req, t_ka_ack, t_k_sk_ack, t_k_lk_ack});
    end
    t_k_lk_req = 1'b0;
    t_ka_req   = 1'b0;
    run_txn(4'd2, 0, 0);
    checks++;
    if (err_stray !== 1'b1) begin
      errors++;
      $display("FAIL stray_sticky: got %b want 1", err_stray);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if ({err_stray, err_timeout} !== 2'b00) begin
      errors++;
      $display("FAIL stray_clear: got %b want 00", {err_stray, err_timeout});
    end
  endtask

  task automatic test_timeout();
    t_ka_req = 1'b1; k_ctrl = 4'd1;
    repeat (3) step();
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got %b want 0", err_timeout);
    end
    repeat (4) step();
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_set: got %b want 1", err_timeout);
    end
    t_ka_req = 1'b0;
    run_txn(4'd1, 0, 1);
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got %b want 1", err_timeout);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: got %b want 0", err_timeout);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    t_ka_req = 1'b1; k_ctrl = 4'd9; t_k_lk_req = 1'b1;
    step();
    checks++;
    if (i_kj_req !== 1'b1) begin
      errors++;
      $display("FAIL rmid_issue: got %b want 1", i_kj_req);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({i_kj_req, i_kj_lk, t_ka_ack, t_k_lk_ack, txn_cnt} !== 6'b0) begin
      errors++;
      $display("FAIL rmid_async: got %b want 000000",
               {i_kj_req, i_kj_lk, t_ka_ack, t_k_lk_ack, txn_cnt});
    end
    @(negedge clk);
    reset   = 1'b0;
    exp_cnt = 2'd0;
    sb.delete();
    push_exp(1'b1);
    n = 0;
    do begin
      step();
      n++;
    end while (i_kj_req !== 1'b1 && n < 8);
    checks++;
    if ({i_kj_req, i_kj_lk} !== 2'b11) begin
      errors++;
      $display("FAIL rmid_rejoin: got req=%b lk=%b want 1 1", i_kj_req, i_kj_lk);
    end
    i_kj_ack = 1'b1;
    step();
    checks++;
    if ({t_ka_ack, t_k_lk_ack, txn_cnt} !== {2'b11, sb[0].cnt}) begin
      errors++;
      $display("FAIL rmid_done: got %b want %b", {t_ka_ack, t_k_lk_ack, txn_cnt},
               {2'b11, sb[0].cnt});
    end
    void'(sb.pop_front());
    drop_all();
    step();
  endtask

  task automatic test_back_to_back();
    test_reset();
    run_txn(4'd0,  0, 0);
    run_txn(4'd15, 1, 0);
    run_txn(4'd7,  0, 2);
    run_txn(4'd8,  2, 1);
    run_txn(4'd4,  0, 0);
    checks++;
    if (txn_cnt !== 2'd1) begin
      errors++;
      $display("FAIL b2b_final_cnt: got %0d want 1", txn_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_sk_basic();
    test_lk_late();
    test_stray();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
